// File: rtl/rv32_br_resolve.sv
// Branch/jump resolution: decides direction from the ALU {N,Z,C,V} flags, computes the target,
// and on a mispredict issues a registered PC redirect followed by a multi-cycle flush.
module rv32_br_resolve #(
    parameter int unsigned FLUSH_CYC = 2,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             is_branch_i,
    input  logic             is_jal_i,
    input  logic             is_jalr_i,
    input  logic [2:0]       funct3_i,
    input  logic [3:0]       flg_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      imm_i,
    input  logic [31:0]      rs1_i,
    input  logic             pred_taken_i,
    output logic             resp_valid_o,
    output logic             taken_o,
    output logic [31:0]      link_o,
    output logic             redirect_o,
    output logic [31:0]      redirect_pc_o,
    output logic             flush_o,
    output logic             misalign_o,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] mis_cnt_o
);

    typedef enum logic [1:0] {S_IDLE, S_RESP, S_FLUSH} state_t;

    state_t           r_state;
    logic [3:0]       r_fcnt;
    logic             r_resp_valid;
    logic             r_taken;
    logic [31:0]      r_link;
    logic             r_redirect;
    logic [31:0]      r_redirect_pc;
    logic             r_flush;
    logic             r_misalign;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_mis_cnt;

    logic             w_n, w_z, w_c, w_v;
    logic             w_cond;
    logic             w_illegal;
    logic             w_taken;
    logic [31:0]      w_sum;
    logic [31:0]      w_target;
    logic [31:0]      w_link;
    logic [31:0]      w_next_pc;
    logic             w_misalign;
    logic             w_redirect;
    logic             w_accept;

    assign {w_n, w_z, w_c, w_v} = flg_i;

    always_comb begin
        w_cond = 1'b0;
        case (funct3_i)
            3'b000:  w_cond = w_z;
            3'b001:  w_cond = ~w_z;
            3'b100:  w_cond = w_n ^ w_v;
            3'b101:  w_cond = ~(w_n ^ w_v);
            3'b110:  w_cond = ~w_c;
            3'b111:  w_cond = w_c;
            default: w_cond = 1'b0;
        endcase
    end

    assign w_illegal  = is_branch_i & (funct3_i[2:1] == 2'b01);
    assign w_taken    = is_jal_i | is_jalr_i | (is_branch_i & w_cond);
    assign w_sum      = (is_jalr_i ? rs1_i : pc_i) + imm_i;
    assign w_target   = {w_sum[31:1], w_sum[0] & ~is_jalr_i};
    assign w_link     = pc_i + 32'd4;
    assign w_next_pc  = w_taken ? w_target : w_link;
    assign w_misalign = w_taken & w_target[1];
    // Illegal conditions never redirect, even when the predictor guessed taken.
    assign w_redirect = (w_taken != pred_taken_i) & ~w_illegal & ~w_misalign;

    assign ready_o  = rst_ni & (r_state == S_IDLE);
    assign w_accept = valid_i & ready_o & (is_branch_i | is_jal_i | is_jalr_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state       <= S_IDLE;
            r_fcnt        <= '0;
            r_resp_valid  <= 1'b0;
            r_taken       <= 1'b0;
            r_link        <= '0;
            r_redirect    <= 1'b0;
            r_redirect_pc <= '0;
            r_flush       <= 1'b0;
            r_misalign    <= 1'b0;
            r_br_cnt      <= '0;
            r_mis_cnt     <= '0;
        end else begin
            r_resp_valid <= 1'b0;
            r_redirect   <= 1'b0;
            r_misalign   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state      <= S_RESP;
                        r_resp_valid <= 1'b1;
                        r_taken      <= w_taken;
                        r_link       <= w_link;
                        r_redirect   <= w_redirect;
                        r_flush      <= w_redirect;
                        r_misalign   <= w_misalign;
                        if (w_redirect) begin
                            r_redirect_pc <= w_next_pc;
                        end
                        // Counters update on the accept edge so the RESP cycle already shows them.
                        if (r_br_cnt != '1) begin
                            r_br_cnt <= r_br_cnt + 1'b1;
                        end
                        if (w_redirect && (r_mis_cnt != '1)) begin
                            r_mis_cnt <= r_mis_cnt + 1'b1;
                        end
                    end
                end
                S_RESP: begin
                    if (r_flush) begin
                        r_state <= S_FLUSH;
                        r_fcnt  <= 4'(FLUSH_CYC - 1);
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    if (r_fcnt == '0) begin
                        r_flush <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_fcnt <= r_fcnt - 1'b1;
                    end
                end
                default: begin
                    r_flush <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign resp_valid_o  = r_resp_valid;
    assign taken_o       = r_taken;
    assign link_o        = r_link;
    assign redirect_o    = r_redirect;
    assign redirect_pc_o = r_redirect_pc;
    assign flush_o       = r_flush;
    assign misalign_o    = r_misalign;
    assign br_cnt_o      = r_br_cnt;
    assign mis_cnt_o     = r_mis_cnt;

endmodule

// File: tb/tb_rv32_br_resolve.sv
// Self-checking bench for rv32_br_resolve: directed plan steps plus random requests whose
// expected outcome is derived from the real rs1/rs2 comparison, not from the flag decode.
module tb_rv32_br_resolve;

    localparam int unsigned FC = 2;
    localparam int unsigned CW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid, ready;
    logic          is_br, is_jal, is_jalr;
    logic [2:0]    f3;
    logic [3:0]    flg;
    logic [31:0]   pc, imm, rs1;
    logic          pred;
    logic          resp_valid, taken, redirect, flush, misalign;
    logic [31:0]   link, redirect_pc;
    logic [CW-1:0] br_cnt, mis_cnt;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] m_rpc;
    int unsigned m_br, m_mis;
    localparam int unsigned SAT = (1 << CW) - 1;

    rv32_br_resolve #(.FLUSH_CYC(FC), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid), .ready_o(ready),
        .is_branch_i(is_br), .is_jal_i(is_jal), .is_jalr_i(is_jalr),
        .funct3_i(f3), .flg_i(flg), .pc_i(pc), .imm_i(imm), .rs1_i(rs1),
        .pred_taken_i(pred), .resp_valid_o(resp_valid), .taken_o(taken),
        .link_o(link), .redirect_o(redirect), .redirect_pc_o(redirect_pc),
        .flush_o(flush), .misalign_o(misalign), .br_cnt_o(br_cnt), .mis_cnt_o(mis_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // kind: 0 none, 1 branch, 2 jal, 3 jalr. exp_tk is the architectural direction.
    task automatic run_req(input int kind, input logic [2:0] c3, input logic [3:0] fl,
                           input logic [31:0] p, input logic [31:0] im, input logic [31:0] r1,
                           input logic pr, input logic exp_tk);
        logic [31:0] tgt, lnk, nxt;
        logic        bad, mal, redir;
        int          lows, fls, rps, k;
        tgt   = (kind == 3) ? ((r1 + im) & 32'hFFFF_FFFE) : (p + im);
        lnk   = p + 32'd4;
        nxt   = exp_tk ? tgt : lnk;
        mal   = exp_tk & tgt[1];
        bad   = (kind == 1) && (c3 == 3'b010 || c3 == 3'b011);
        redir = (kind != 0) && (exp_tk != pr) && !bad && !mal;

        @(negedge clk);
        valid = 1'b1; is_br = (kind == 1); is_jal = (kind == 2); is_jalr = (kind == 3);
        f3 = c3; flg = fl; pc = p; imm = im; rs1 = r1; pred = pr;
        k = 0;
        while (!ready && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("ready_wait", {31'd0, ready}, 32'd1);
        @(posedge clk);
        #1;
        if (kind != 0) begin
            if (m_br < SAT) m_br++;
            if (redir && m_mis < SAT) m_mis++;
            if (redir) m_rpc = nxt;
            // Present a different request while busy; it must not be captured.
            is_br = 1'b0; is_jal = 1'b1; is_jalr = 1'b0; pc = 32'h0000_4000; imm = 32'h8;
        end else begin
            valid = 1'b0;
        end
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, kind != 0});
        chk("misalign", {31'd0, misalign}, {31'd0, kind != 0 && mal});
        chk("redirect", {31'd0, redirect}, {31'd0, redir});
        if (kind != 0) begin
            chk("taken", {31'd0, taken}, {31'd0, exp_tk});
            chk("link", link, lnk);
        end
        lows = 0; fls = 0; rps = 0; k = 0;
        forever begin
            if (!ready) lows++;
            if (flush) fls++;
            if (resp_valid) rps++;
            if (ready || k >= 40) break;
            @(posedge clk);
            #1;
            k++;
        end
        valid = 1'b0;
        chk("ready_low_cycles", lows, (kind == 0) ? 0 : (redir ? FC + 1 : 1));
        chk("flush_cycles", fls, redir ? FC + 1 : 0);
        chk("resp_pulses", rps, (kind != 0) ? 1 : 0);
        chk("redirect_pc", redirect_pc, m_rpc);
        chk("br_cnt", {28'd0, br_cnt}, m_br);
        chk("mis_cnt", {28'd0, mis_cnt}, m_mis);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_ready", {31'd0, ready}, 32'd0);
        chk("rst_flush", {31'd0, flush}, 32'd0);
        chk("rst_br_cnt", {28'd0, br_cnt}, 32'd0);
        chk("rst_mis_cnt", {28'd0, mis_cnt}, 32'd0);
        chk("rst_redirect_pc", redirect_pc, 32'd0);
        m_br = 0; m_mis = 0; m_rpc = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [31:0] a, b, d, p, im;
        logic [3:0]  fl;
        logic [2:0]  c3;
        logic        tk, pr;
        int          kind;

        rst_n = 1'b0; valid = 1'b0; is_br = 1'b0; is_jal = 1'b0; is_jalr = 1'b0;
        f3 = '0; flg = '0; pc = '0; imm = '0; rs1 = '0; pred = 1'b0;
        m_br = 0; m_mis = 0; m_rpc = 32'd0;
        repeat (2) @(posedge clk);
        do_reset();

        run_req(1, 3'b000, 4'b0100, 32'h100, 32'h20, 32'h0, 1'b0, 1'b1);          // BEQ taken, mispredict
        chk("beq_target", redirect_pc, 32'h120);
        run_req(1, 3'b110, 4'b0010, 32'h200, 32'h40, 32'h0, 1'b0, 1'b0);          // BLTU, C=1
        run_req(1, 3'b100, 4'b1011, 32'h100, 32'h20, 32'h0, 1'b1, 1'b0);          // BLT, N^V=0
        chk("blt_fallthrough", redirect_pc, 32'h104);
        run_req(3, 3'b000, 4'b0000, 32'h300, 32'h0, 32'h1003, 1'b1, 1'b1);        // JALR misaligned
        run_req(2, 3'b000, 4'b0000, 32'hFFFF_FFF0, 32'h20, 32'h0, 1'b0, 1'b1);    // JAL wraps
        chk("jal_wrap", redirect_pc, 32'h10);
        run_req(1, 3'b010, 4'b0100, 32'h500, 32'h10, 32'h0, 1'b0, 1'b0);          // illegal funct3
        run_req(1, 3'b011, 4'b0101, 32'h500, 32'h10, 32'h0, 1'b1, 1'b0);          // illegal, pred taken
        run_req(0, 3'b000, 4'b0100, 32'h600, 32'h10, 32'h0, 1'b0, 1'b0);          // no type: ignored

        for (int i = 0; i < 80; i++) begin
            a = $urandom;
            b = ($urandom_range(0, 3) == 0) ? a : $urandom;
            if ($urandom_range(0, 3) == 0) b = {~a[31], $urandom_range(0, 255) == 0 ? a[30:0] : b[30:0]};
            d  = a - b;
            fl = {d[31], d == 32'd0, a >= b, (a[31] != b[31]) && (d[31] != a[31])};
            c3 = 3'($urandom_range(0, 7));
            case (c3)
                3'b000:  tk = (a == b);
                3'b001:  tk = (a != b);
                3'b100:  tk = ($signed(a) < $signed(b));
                3'b101:  tk = ($signed(a) >= $signed(b));
                3'b110:  tk = (a < b);
                3'b111:  tk = (a >= b);
                default: tk = 1'b0;
            endcase
            kind = $urandom_range(0, 5);
            if (kind >= 4) kind = 1;
            if (kind == 2 || kind == 3) tk = 1'b1;
            if (kind == 0) tk = 1'b0;
            p  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
            im = $urandom_range(0, 7) == 0 ? $urandom : {{20{1'b0}}, 12'($urandom)};
            pr = 1'($urandom);
            run_req(kind, c3, fl, p, im, a, pr, tk);
        end

        // Asynchronous reset in the middle of a flush.
        @(negedge clk);
        valid = 1'b1; is_br = 1'b1; is_jal = 1'b0; is_jalr = 1'b0;
        f3 = 3'b000; flg = 4'b0100; pc = 32'h700; imm = 32'h40; pred = 1'b0;
        while (!ready) @(negedge clk);
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("pre_rst_flush", {31'd0, flush}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midflush_flush", {31'd0, flush}, 32'd0);
        chk("midflush_br_cnt", {28'd0, br_cnt}, 32'd0);
        chk("midflush_mis_cnt", {28'd0, mis_cnt}, 32'd0);
        chk("midflush_ready", {31'd0, ready}, 32'd0);
        m_br = 0; m_mis = 0; m_rpc = 32'd0;
        @(negedge clk);
        rst_n = 1'b1;
        run_req(1, 3'b001, 4'b0000, 32'h800, 32'h80, 32'h0, 1'b0, 1'b1);          // BNE after reset

        // Drive both counters into saturation with forced mispredicts.
        for (int i = 0; i < int'(SAT) + 4; i++) begin
            run_req(2, 3'b000, 4'b0000, 32'h1000 + 32'(i * 16), 32'h8, 32'h0, 1'b0, 1'b1);
        end
        chk("sat_br_cnt", {28'd0, br_cnt}, SAT);
        chk("sat_mis_cnt", {28'd0, mis_cnt}, SAT);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
